sync_fwft_fifo: RTL and testbench
=================================

Name: sync_fwft_fifo

Overview:
Single-clock, first-word-fall-through (FWFT) FIFO used as the buffering primitive in chipset bridges, e.g. for AXI-Lite address, data and type queues feeding NoC flit builders. The head entry is always visible on rdata while the FIFO is non-empty. Assertion of ren pops the head entry. Writes are presented with wval and are dropped when the FIFO is full.

Parameters:
DSIZE, 64, data width in bits.
ASIZE, 5, pointer width in bits; includes one extra wrap bit.
MEMSIZE, 16, storage depth in entries; must equal 2^(ASIZE-1).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears the FIFO immediately.
wval  input  1  write request; writes wdata when full=0.
wdata  input  DSIZE  write data.
ren  input  1  read/pop request; pops the head entry when empty=0.
rdata  output  DSIZE  head entry (FWFT); valid whenever empty=0.
empty  output  1  1 when occupancy is 0.
full  output  1  1 when occupancy equals MEMSIZE.

Behaviour:
- State: storage array mem[MEMSIZE] of DSIZE bits, plus ASIZE-bit write pointer wp and read pointer rp.
- Storage is indexed by the low ASIZE-1 pointer bits; the MSB is the wrap bit.
- Reset (reset=0, asynchronous): wp=0, rp=0, so empty=1 and full=0 immediately. Storage contents are not cleared.
- empty = (wp == rp). This is combinational from the registered pointers.
- full = (wp[ASIZE-1] != rp[ASIZE-1]) && (wp[ASIZE-2:0] == rp[ASIZE-2:0]).
- Write: on a clk rising edge with wval=1 and full=0, mem[wp low bits] <= wdata and wp <= wp+1, wrapping modulo 2^ASIZE.
- Write when full=1 is ignored: no pointer change and no storage change.
- Read: on a clk rising edge with ren=1 and empty=0, rp <= rp+1, wrapping modulo 2^ASIZE.
- Read when empty=1 is ignored.
- rdata = mem[rp low bits] combinationally when empty=0; rdata = 0 when empty=1.
- After reset, rdata = 0.
- Latency: data written at edge N is visible on rdata and empty=0 after edge N, i.e. in the next cycle. There is no combinational write-to-read bypass.
- Simultaneous wval and ren when 0 < occupancy < MEMSIZE: both are performed and occupancy is unchanged.
- Simultaneous wval and ren when empty: only the write happens; the read is ignored.
- Simultaneous wval and ren when full: only the read happens; the write is dropped. full and empty are sampled before the edge.
- Pointers wrap indefinitely; ordering is strictly FIFO across wrap.
- Reset asserted mid-operation discards all contents immediately.
- Reset release is synchronised externally; no internal reset synchroniser.

Optional Feature:
Macro SYNC_FIFO_LEVEL_EN.
- Defined: adds output port level [ASIZE-1:0], equal to wp - rp modulo 2^ASIZE. This is the current occupancy, 0..MEMSIZE. level is 0 during and after reset and updates on the same edge as the pointers.
- Not defined: the port does not exist and no extra logic is generated; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with wval=1 → empty=1, full=0, rdata=0, no write. Release, then write 0xA5 → next cycle empty=0, rdata=0xA5.
- Fill/full: write 16 values 0..15 with no reads → full=1 after the 16th edge. A 17th write of 0xFF is dropped. Then read 16 times → rdata = 0,1,...,15 in order; empty=1 after the last pop.
- Underflow: with the FIFO empty, pulse ren for 3 cycles, then write 0x7 → empty=0, rdata=0x7; the pointers were not corrupted by the empty reads.
- Simultaneous read/write: at occupancy 5, assert wval and ren for 20 cycles → occupancy stays 5 (level=5 when SYNC_FIFO_LEVEL_EN). Data order is preserved across pointer wrap.
- Boundary collisions: full with wval and ren together → one pop, the write is dropped, full=0 next. Empty with wval and ren together → one write, empty=0, rdata = the written value.
- Async reset mid-stream: with 9 entries held, drop reset between clock edges → empty=1 and full=0 without a clock edge; the next write/read sequence starts fresh.

Source files
------------

// File: rtl/sync_fwft_fifo.sv
// rtl/sync_fwft_fifo.sv - single-clock first-word-fall-through FIFO
// Optional occupancy output `level` is enabled by defining SYNC_FIFO_LEVEL_EN.
module sync_fwft_fifo #(
    parameter int DSIZE   = 64,
    parameter int ASIZE   = 5,
    parameter int MEMSIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wval,
    input  logic [DSIZE-1:0] wdata,
    input  logic             ren,
    output logic [DSIZE-1:0] rdata,
    output logic             empty,
`ifdef SYNC_FIFO_LEVEL_EN
    output logic [ASIZE-1:0] level,
`endif
    output logic             full
);

    localparam logic [ASIZE-1:0] PTR_ONE = 1;

    logic [DSIZE-1:0] mem [MEMSIZE];
    logic [ASIZE-1:0] wp;
    logic [ASIZE-1:0] rp;
    logic             do_write;
    logic             do_read;

    assign empty = (wp == rp);
    assign full  = (wp[ASIZE-1] != rp[ASIZE-1]) && (wp[ASIZE-2:0] == rp[ASIZE-2:0]);

    // Flags are taken from the registered pointers, so a collision at a boundary
    // only performs the operation that is legal for the pre-edge state.
    assign do_write = wval && !full;
    assign do_read  = ren && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_write) begin
                wp <= wp + PTR_ONE;
            end
            if (do_read) begin
                rp <= rp + PTR_ONE;
            end
        end
    end

    // Storage is deliberately left out of reset; empty masks stale entries.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[wp[ASIZE-2:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rp[ASIZE-2:0]];

`ifdef SYNC_FIFO_LEVEL_EN
    assign level = wp - rp;
`endif

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// tb/tb_sync_fwft_fifo.sv - directed scoreboard bench for sync_fwft_fifo
module tb_sync_fwft_fifo;

    localparam int DSIZE   = 64;
    localparam int ASIZE   = 5;
    localparam int MEMSIZE = 16;

    logic             clk;
    logic             reset;
    logic             wval;
    logic [DSIZE-1:0] wdata;
    logic             ren;
    logic [DSIZE-1:0] rdata;
    logic             empty;
    logic             full;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [ASIZE-1:0] level;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [DSIZE-1:0] sb [$];

    sync_fwft_fifo #(
        .DSIZE  (DSIZE),
        .ASIZE  (ASIZE),
        .MEMSIZE(MEMSIZE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .wval (wval),
        .wdata(wdata),
        .ren  (ren),
        .rdata(rdata),
        .empty(empty),
`ifdef SYNC_FIFO_LEVEL_EN
        .level(level),
`endif
        .full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DSIZE-1:0] obs, input logic [DSIZE-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        logic [DSIZE-1:0] head;
        head = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, "_empty"}, {63'd0, empty}, {63'd0, sb.size() == 0});
        chk({tag, "_full"}, {63'd0, full}, {63'd0, sb.size() == MEMSIZE});
        chk({tag, "_rdata"}, rdata, head);
`ifdef SYNC_FIFO_LEVEL_EN
        chk({tag, "_level"}, {{(DSIZE-ASIZE){1'b0}}, level}, DSIZE'(sb.size()));
`endif
    endtask

    // One clock: drive inputs, predict from pre-edge occupancy, then compare.
    task automatic cycle(input string tag, input logic w, input logic [DSIZE-1:0] d, input logic r);
        logic do_w;
        logic do_r;
        wval  = w;
        wdata = d;
        ren   = r;
        do_w  = w && (sb.size() < MEMSIZE);
        do_r  = r && (sb.size() > 0);
        if (do_r) begin
            chk({tag, "_pop"}, rdata, sb[0]);
        end
        @(posedge clk);
        #1;
        if (do_r) begin
            void'(sb.pop_front());
        end
        if (do_w) begin
            sb.push_back(d);
        end
        wval = 1'b0;
        ren  = 1'b0;
        chk_flags(tag);
    endtask

    initial begin
        reset = 1'b0;
        wval  = 1'b1;
        wdata = 64'hDEAD_BEEF;
        ren   = 1'b0;
        #1;
        chk("rst_async_empty", {63'd0, empty}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk_flags("rst_hold");
        reset = 1'b1;
        wval  = 1'b0;

        cycle("first_wr", 1'b1, 64'hA5, 1'b0);
        cycle("first_rd", 1'b0, '0, 1'b1);

        for (int i = 0; i < MEMSIZE; i++) begin
            cycle("fill", 1'b1, DSIZE'(i), 1'b0);
        end
        cycle("overflow", 1'b1, 64'hFF, 1'b0);
        for (int i = 0; i < MEMSIZE; i++) begin
            cycle("drain", 1'b0, '0, 1'b1);
        end

        repeat (3) cycle("underflow", 1'b0, '0, 1'b1);
        cycle("after_uflow", 1'b1, 64'h7, 1'b0);
        cycle("after_uflow_rd", 1'b0, '0, 1'b1);

        for (int i = 0; i < 5; i++) begin
            cycle("pre5", 1'b1, 64'h100 + DSIZE'(i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle("simul", 1'b1, {32'hC0DE_0000, $urandom}, 1'b1);
        end
        chk("simul_occ", DSIZE'(sb.size()), 64'd5);

        while (sb.size() < MEMSIZE) begin
            cycle("to_full", 1'b1, 64'h200 + DSIZE'(sb.size()), 1'b0);
        end
        cycle("full_coll", 1'b1, 64'hEE, 1'b1);
        chk("full_coll_occ", DSIZE'(sb.size()), DSIZE'(MEMSIZE - 1));
        while (sb.size() > 0) begin
            cycle("drain2", 1'b0, '0, 1'b1);
        end
        cycle("empty_coll", 1'b1, 64'h42, 1'b1);
        chk("empty_coll_occ", DSIZE'(sb.size()), 64'd1);
        cycle("empty_coll_rd", 1'b0, '0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            cycle("pre_rst", 1'b1, 64'h300 + DSIZE'(i), 1'b0);
        end
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        chk_flags("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk_flags("mid_rst_edge");
        for (int i = 0; i < 3; i++) begin
            cycle("fresh_wr", 1'b1, 64'h400 + DSIZE'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle("fresh_rd", 1'b0, '0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
